// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: spike width, saturation
// ceiling, scan FSM states and the default synaptic weight.
// Pure declarations; no timing or flow control.
package snn_pkg;
  localparam int SPIKE_W = 32;
  localparam logic [SPIKE_W-1:0] SPIKE_MAX = 32'hFFFF_FFFF;
  localparam logic [SPIKE_W-1:0] DEFAULT_W = 32'd900000000;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} syn_state_t;

  // Index width for an N-entry table; a single entry still needs one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/syn_weight_rf.sv
// Per-synapse weight register file: one write port, one combinational read port.
// Latency: writes visible the cycle after the strobe; reads are same-cycle.
// Backpressure: none; out-of-range write addresses are dropped.
module syn_weight_rf #(
  parameter int N_IN = 8,
  parameter int AW = 3,
  parameter logic [31:0] DEFAULT_W = 32'd900000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);
  import snn_pkg::*;

  logic [SPIKE_W-1:0] r_w [N_IN];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < N_IN; k++) r_w[k] <= DEFAULT_W;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (i_wr_en && i_wr_addr == AW'(k)) r_w[k] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_w[i_rd_addr];
endmodule

// File: rtl/synapse_integrator.sv
// Latches presynaptic spikes per window and serially sums their weights, saturating.
// Latency: one-cycle pulse N_IN+1 cycles after the window's terminal count.
// Backpressure: none; the downstream neuron consumes every pulse unconditionally.
module synapse_integrator #(
  parameter int N_IN = 8,
  parameter int WINDOW_CYC = 1000,
  parameter logic [31:0] DEFAULT_W = 32'd900000000,
  localparam int AW = snn_pkg::addr_w(N_IN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_IN-1:0] i_pre_spike,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [31:0]     i_wr_data,
  output logic [31:0]     o_spike,
  output logic            o_valid,
  output logic            o_sat
);
  import snn_pkg::*;

  localparam int CW = $clog2(WINDOW_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW_CYC - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);

  generate
    if (WINDOW_CYC <= N_IN + 2) begin : g_bad_window
      $fatal(1, "synapse_integrator: WINDOW_CYC must exceed N_IN+2");
    end
  endgenerate

  logic [CW-1:0]      r_cnt;
  logic [N_IN-1:0]    r_pend;
  logic [N_IN-1:0]    r_snap;
  syn_state_t         r_state;
  logic [AW-1:0]      r_idx;
  logic [SPIKE_W-1:0] r_acc;
  logic               r_sat_acc;
  logic [SPIKE_W-1:0] r_spike;
  logic               r_valid;
  logic               r_sat;

  logic               w_term;
  logic [SPIKE_W-1:0] w_rd_w;
  logic [SPIKE_W:0]   w_sum;

  assign w_term = (r_cnt == LAST_CNT);
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_rd_w};

  syn_weight_rf #(
    .N_IN      (N_IN),
    .AW        (AW),
    .DEFAULT_W (DEFAULT_W)
  ) u_weight_rf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_w)
  );

  // Clearing pending on the terminal cycle makes the next cycle's spikes
  // belong to the following window.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      r_cnt  <= w_term ? '0 : r_cnt + CW'(1);
      r_pend <= w_term ? '0 : (r_pend | i_pre_spike);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_snap    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_sat_acc <= 1'b0;
      r_spike   <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_spike <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_term) begin
            r_snap    <= r_pend | i_pre_spike;
            r_acc     <= '0;
            r_sat_acc <= 1'b0;
            r_idx     <= '0;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (r_snap[r_idx]) begin
            if (w_sum[SPIKE_W]) begin
              r_acc     <= SPIKE_MAX;
              r_sat_acc <= 1'b1;
            end else begin
              r_acc <= w_sum[SPIKE_W-1:0];
            end
          end
          if (r_idx == LAST_IDX) r_state <= EMIT;
          else                   r_idx   <= r_idx + AW'(1);
        end
        EMIT: begin
          if (r_acc != '0) begin
            r_spike <= r_acc;
            r_valid <= 1'b1;
            r_sat   <= r_sat_acc;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_spike = r_spike;
  assign o_valid = r_valid;
  assign o_sat   = r_sat;
endmodule

// File: tb/tb_synapse_integrator.sv
// Bench for synapse_integrator: directed window scenarios plus random spikes and
// weight writes, checked cycle by cycle against a window-level sum model.
module tb_synapse_integrator;
  localparam int N_IN = 4;
  localparam int WIN  = 16;
  localparam logic [31:0] DEF_W = 32'd900000000;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [N_IN-1:0] i_pre_spike = '0;
  logic            i_wr_en = 1'b0;
  logic [1:0]      i_wr_addr = '0;
  logic [31:0]     i_wr_data = '0;
  logic [31:0]     o_spike;
  logic            o_valid;
  logic            o_sat;

  synapse_integrator #(
    .N_IN       (N_IN),
    .WINDOW_CYC (WIN),
    .DEFAULT_W  (DEF_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pre_spike (i_pre_spike),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_spike     (o_spike),
    .o_valid     (o_valid),
    .o_sat       (o_sat)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Window-level model: which inputs fired, and the plain sum of their weights.
  int              c;
  int              m_t;
  logic [N_IN-1:0] m_pend;
  logic [N_IN-1:0] m_snap;
  longint unsigned m_total;
  longint unsigned m_w [N_IN];

  logic [31:0] last_spike;
  logic        last_sat;
  int          n_pulse;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0;
    m_t = -100;
    m_pend = '0;
    m_snap = '0;
    m_total = 0;
    for (int k = 0; k < N_IN; k++) m_w[k] = 64'(DEF_W);
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs after the edge.
  task automatic cyc(input logic [N_IN-1:0] spk, input logic we,
                     input logic [1:0] wa, input logic [31:0] wd);
    logic            ev;
    logic            es;
    longint unsigned ex;
    i_pre_spike = spk;
    i_wr_en     = we;
    i_wr_addr   = wa;
    i_wr_data   = wd;
    ev = 1'b0; es = 1'b0; ex = 0;
    for (int k = 0; k < N_IN; k++)
      if (m_t >= 0 && c == m_t + 1 + k && m_snap[k]) m_total += m_w[k];
    if (m_t >= 0 && c == m_t + N_IN + 1 && m_total != 0) begin
      ev = 1'b1;
      es = (m_total > MAXV);
      ex = es ? MAXV : m_total;
    end
    if (we && int'(wa) < N_IN) m_w[wa] = 64'(wd);
    m_pend |= spk;
    if (c % WIN == WIN - 1) begin
      m_snap  = m_pend;
      m_pend  = '0;
      m_t     = c;
      m_total = 0;
    end
    @(posedge i_clk);
    #1;
    chk("valid", 64'(o_valid), 64'(ev));
    chk("spike", 64'(o_spike), ex);
    chk("sat",   64'(o_sat),   64'(es));
    if (o_valid) begin
      last_spike = o_spike;
      last_sat   = o_sat;
      n_pulse++;
    end
    c++;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic at_count(input int cnt);
    while (c % WIN != cnt) cyc('0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_spike", 64'(o_spike), 64'd0);
    chk("rst_sat",   64'(o_sat),   64'd0);
    i_pre_spike = '0;
    i_wr_en     = 1'b0;
    repeat (2) @(negedge i_clk);
    model_reset();
    i_rst = 1'b1;
  endtask

  initial begin
    int waited;
    logic [N_IN-1:0] rs;
    model_reset();
    n_pulse = 0;
    last_spike = '0;
    last_sat = 1'b0;

    // Reset state and a quiet start.
    do_reset();
    idle(64);
    chk("quiet_pulses", 64'(n_pulse), 64'd0);

    // Single spike on input 0.
    at_count(3);
    cyc(4'b0001, 1'b0, 2'd0, 32'd0);
    idle(20);
    chk("single_w", 64'(last_spike), 64'd900000000);

    // Repeated spikes on one input count once.
    at_count(2);  cyc(4'b0001, 1'b0, 2'd0, 32'd0);
    at_count(5);  cyc(4'b0100, 1'b0, 2'd0, 32'd0);
    at_count(9);  cyc(4'b0001, 1'b0, 2'd0, 32'd0);
    idle(20);
    chk("dup_once", 64'(last_spike), 64'd1800000000);

    // Terminal-count spike goes to the current window; count-0 spike to the next.
    at_count(15);
    n_pulse = 0;
    cyc(4'b0010, 1'b0, 2'd0, 32'd0);
    cyc(4'b0010, 1'b0, 2'd0, 32'd0);
    idle(30);
    chk("term_pulses", 64'(n_pulse), 64'd2);
    chk("term_w", 64'(last_spike), 64'd900000000);

    // Saturation.
    cyc('0, 1'b1, 2'd0, 32'd3000000000);
    cyc('0, 1'b1, 2'd1, 32'd3000000000);
    at_count(4);
    cyc(4'b0011, 1'b0, 2'd0, 32'd0);
    idle(20);
    chk("sat_val", 64'(last_spike), 64'hFFFF_FFFF);
    chk("sat_flag", 64'(last_sat), 64'd1);

    // Reset during SCAN discards the pending sum.
    at_count(6);
    cyc(4'b0001, 1'b0, 2'd0, 32'd0);
    at_count(15);
    idle(2);
    do_reset();
    n_pulse = 0;
    idle(2 * WIN);
    chk("rst_discard", 64'(n_pulse), 64'd0);
    at_count(3);
    cyc(4'b0001, 1'b0, 2'd0, 32'd0);
    idle(20);
    chk("rst_weights", 64'(last_spike), 64'd900000000);

    // Reset while a pulse is on the outputs clears them asynchronously.
    at_count(3);
    cyc(4'b0100, 1'b0, 2'd0, 32'd0);
    waited = 0;
    while (!o_valid && waited < 40) begin
      cyc('0, 1'b0, 2'd0, 32'd0);
      waited++;
    end
    chk("pulse_seen", 64'(o_valid), 64'd1);
    i_rst = 1'b0;
    #1;
    chk("async_valid", 64'(o_valid), 64'd0);
    chk("async_spike", 64'(o_spike), 64'd0);
    do_reset();

    // Random spikes and weight writes, including zero and near-max weights.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] wd;
      rs = ($urandom_range(0, 5) == 0) ? N_IN'($urandom) : '0;
      case ($urandom_range(0, 3))
        0:       wd = 32'd0;
        1:       wd = $urandom;
        2:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: wd = 32'($urandom_range(0, 2000000000));
      endcase
      cyc(rs, ($urandom_range(0, 9) == 0), 2'($urandom), wd);
    end
    idle(24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
